// File: rtl/struct_s.sv
// Shared types and constants for the PDU path: metadata record, action codes,
// and the PDU flit limit.
package struct_s;

  localparam int PDUID_WIDTH   = 8;
  localparam int ACTION_WIDTH  = 2;
  localparam int MAX_PDU_FLITS = 31;

  localparam logic [ACTION_WIDTH-1:0] ACTION_CHECK   = 2'd1;
  localparam logic [ACTION_WIDTH-1:0] ACTION_NOCHECK = 2'd2;

  typedef struct packed {
    logic [PDUID_WIDTH-1:0]  pdu_id;
    logic [ACTION_WIDTH-1:0] action;
    logic [4:0]              flits;
    logic [10:0]             pdu_size;
  } pdu_metadata_t;

  localparam int PDU_META_WIDTH = $bits(pdu_metadata_t);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FWD,
    ST_TRUNC,
    ST_DISCARD
  } pdu_gen_state_e;

  function automatic logic [10:0] pdu_size_f(input logic [4:0] flits, input logic [5:0] empty);
    return {flits, 6'd0} - {5'd0, empty};
  endfunction

endpackage

// File: rtl/pdu_gen.sv
// Segments classified packets into PDUs: pops action and pdu_id at sop, forwards
// flits with one cycle of latency, truncates long packets and emits one metadata word per PDU.
//  state      | meaning
//  ST_IDLE    | waiting for sop + action (+ pdu_id for CHECK); stray flits dropped
//  ST_FWD     | forwarding flits of the current PDU
//  ST_TRUNC   | PDU already closed at the flit limit; dropping the packet tail
//  ST_DISCARD | packet action is neither CHECK nor NOCHECK; dropping it
module pdu_gen
  import struct_s::*;
#(
  parameter int MAX_FLITS = MAX_PDU_FLITS
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [511:0]              in_pkt_data,
  input  logic                      in_pkt_sop,
  input  logic                      in_pkt_eop,
  input  logic [5:0]                in_pkt_empty,
  input  logic                      in_pkt_valid,
  output logic                      in_pkt_ready,
  input  logic [ACTION_WIDTH-1:0]   in_meta_action,
  input  logic                      in_meta_valid,
  output logic                      in_meta_ready,
  input  logic [PDUID_WIDTH-1:0]    emptylist_data,
  input  logic                      emptylist_valid,
  output logic                      emptylist_ready,
  output logic [511:0]              pdu_gen_data,
  output logic                      pdu_gen_sop,
  output logic                      pdu_gen_eop,
  output logic [5:0]                pdu_gen_empty,
  output logic                      pdu_gen_valid,
  input  logic                      pdu_gen_ready,
  input  logic                      pdu_gen_almost_full,
  output logic [PDU_META_WIDTH-1:0] pdumeta_gen_data,
  output logic                      pdumeta_gen_valid,
  input  logic                      pdumeta_gen_ready,
  output logic [31:0]               stat_pkts,
  output logic [31:0]               stat_trunc,
  output logic [1:0]                err_sticky
);

  localparam logic [4:0] MAX_CNT = 5'(MAX_FLITS);

  pdu_gen_state_e          state_q, state_d;
  logic                    run_q, run_d;
  logic [4:0]              flit_cnt_q, flit_cnt_d;
  logic [PDUID_WIDTH-1:0]  pdu_id_q, pdu_id_d;
  logic [ACTION_WIDTH-1:0] action_q, action_d;
  logic [511:0]            out_data_q, out_data_d;
  logic                    out_sop_q, out_sop_d;
  logic                    out_eop_q, out_eop_d;
  logic [5:0]              out_empty_q, out_empty_d;
  logic                    out_valid_q, out_valid_d;
  pdu_metadata_t           meta_q, meta_d;
  logic                    meta_valid_q, meta_valid_d;
  logic [31:0]             stat_pkts_q, stat_pkts_d;
  logic [31:0]             stat_trunc_q, stat_trunc_d;
  logic [1:0]              err_q, err_d;

  logic                    is_check, is_fwd_act, start_ok;
  logic                    fwd_flit, first;
  logic [4:0]              cnt_next;
  logic [PDUID_WIDTH-1:0]  cur_id;
  logic [ACTION_WIDTH-1:0] cur_action;

  assign is_check   = (in_meta_action == ACTION_CHECK);
  assign is_fwd_act = is_check | (in_meta_action == ACTION_NOCHECK);
  // A pending metadata word blocks the next start, so the meta slot never double-loads.
  assign start_ok   = run_q & (state_q == ST_IDLE) & in_pkt_valid & in_pkt_sop & in_meta_valid &
                      ~meta_valid_q & ~pdu_gen_almost_full & (~is_check | emptylist_valid);

  always_comb begin
    state_d      = state_q;
    run_d        = 1'b1;
    flit_cnt_d   = flit_cnt_q;
    pdu_id_d     = pdu_id_q;
    action_d     = action_q;
    out_data_d   = out_data_q;
    out_sop_d    = 1'b0;
    out_eop_d    = 1'b0;
    out_empty_d  = '0;
    out_valid_d  = 1'b0;
    meta_d       = meta_q;
    meta_valid_d = meta_valid_q;
    stat_pkts_d  = stat_pkts_q;
    stat_trunc_d = stat_trunc_q;
    err_d        = err_q;
    in_pkt_ready    = 1'b0;
    in_meta_ready   = 1'b0;
    emptylist_ready = 1'b0;
    fwd_flit   = 1'b0;
    first      = 1'b0;
    cnt_next   = flit_cnt_q + 5'd1;
    cur_id     = pdu_id_q;
    cur_action = action_q;

    if (meta_valid_q && pdumeta_gen_ready) begin
      meta_valid_d = 1'b0;
      stat_pkts_d  = stat_pkts_q + 32'd1;
    end
    if (out_valid_q && !pdu_gen_ready) err_d[0] = 1'b1;

    case (state_q)
      ST_IDLE: begin
        in_pkt_ready    = run_q & (~in_pkt_sop | start_ok);
        in_meta_ready   = start_ok;
        emptylist_ready = start_ok & is_check;
        if (start_ok) begin
          if (is_fwd_act) begin
            fwd_flit   = 1'b1;
            first      = 1'b1;
            cnt_next   = 5'd1;
            cur_id     = is_check ? emptylist_data : '0;
            cur_action = in_meta_action;
          end else if (!in_pkt_eop) begin
            state_d = ST_DISCARD;
          end
        end
      end
      ST_FWD: begin
        in_pkt_ready = 1'b1;
        if (in_pkt_valid) begin
          if (in_pkt_sop) err_d[1] = 1'b1;
          fwd_flit = 1'b1;
        end
      end
      ST_TRUNC, ST_DISCARD: begin
        in_pkt_ready = 1'b1;
        if (in_pkt_valid) begin
          if (in_pkt_sop) err_d[1] = 1'b1;
          if (in_pkt_eop) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (fwd_flit) begin
      flit_cnt_d  = cnt_next;
      pdu_id_d    = cur_id;
      action_d    = cur_action;
      out_valid_d = 1'b1;
      out_data_d  = in_pkt_data;
      out_sop_d   = first;
      if (in_pkt_eop || cnt_next == MAX_CNT) begin
        out_eop_d       = 1'b1;
        out_empty_d     = in_pkt_eop ? in_pkt_empty : 6'd0;
        meta_valid_d    = 1'b1;
        meta_d.pdu_id   = cur_id;
        meta_d.action   = cur_action;
        meta_d.flits    = cnt_next;
        meta_d.pdu_size = pdu_size_f(cnt_next, out_empty_d);
        state_d         = in_pkt_eop ? ST_IDLE : ST_TRUNC;
        if (!in_pkt_eop) stat_trunc_d = stat_trunc_q + 32'd1;
      end else begin
        state_d = ST_FWD;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      run_q        <= 1'b0;
      flit_cnt_q   <= '0;
      pdu_id_q     <= '0;
      action_q     <= '0;
      out_data_q   <= '0;
      out_sop_q    <= 1'b0;
      out_eop_q    <= 1'b0;
      out_empty_q  <= '0;
      out_valid_q  <= 1'b0;
      meta_q       <= '0;
      meta_valid_q <= 1'b0;
      stat_pkts_q  <= '0;
      stat_trunc_q <= '0;
      err_q        <= '0;
    end else begin
      state_q      <= state_d;
      run_q        <= run_d;
      flit_cnt_q   <= flit_cnt_d;
      pdu_id_q     <= pdu_id_d;
      action_q     <= action_d;
      out_data_q   <= out_data_d;
      out_sop_q    <= out_sop_d;
      out_eop_q    <= out_eop_d;
      out_empty_q  <= out_empty_d;
      out_valid_q  <= out_valid_d;
      meta_q       <= meta_d;
      meta_valid_q <= meta_valid_d;
      stat_pkts_q  <= stat_pkts_d;
      stat_trunc_q <= stat_trunc_d;
      err_q        <= err_d;
    end
  end

  assign pdu_gen_data      = out_data_q;
  assign pdu_gen_sop       = out_sop_q;
  assign pdu_gen_eop       = out_eop_q;
  assign pdu_gen_empty     = out_empty_q;
  assign pdu_gen_valid     = out_valid_q;
  assign pdumeta_gen_data  = meta_q;
  assign pdumeta_gen_valid = meta_valid_q;
  assign stat_pkts         = stat_pkts_q;
  assign stat_trunc        = stat_trunc_q;
  assign err_sticky        = err_q;

endmodule

// File: tb/tb_pdu_gen.sv
// Scoreboard bench for pdu_gen: directed packets push expected flits/metadata,
// a negedge monitor pops and compares whatever the DUT presents.
module tb_pdu_gen;
  import struct_s::*;

  logic                      clk = 1'b0;
  logic                      rst;
  logic [511:0]              in_pkt_data;
  logic                      in_pkt_sop, in_pkt_eop, in_pkt_valid, in_pkt_ready;
  logic [5:0]                in_pkt_empty;
  logic [ACTION_WIDTH-1:0]   in_meta_action;
  logic                      in_meta_valid, in_meta_ready;
  logic [PDUID_WIDTH-1:0]    emptylist_data;
  logic                      emptylist_valid, emptylist_ready;
  logic [511:0]              pdu_gen_data;
  logic                      pdu_gen_sop, pdu_gen_eop, pdu_gen_valid, pdu_gen_ready;
  logic [5:0]                pdu_gen_empty;
  logic                      pdu_gen_almost_full;
  logic [PDU_META_WIDTH-1:0] pdumeta_gen_data;
  logic                      pdumeta_gen_valid, pdumeta_gen_ready;
  logic [31:0]               stat_pkts, stat_trunc;
  logic [1:0]                err_sticky;

  pdu_gen dut (
    .clk(clk), .rst(rst),
    .in_pkt_data(in_pkt_data), .in_pkt_sop(in_pkt_sop), .in_pkt_eop(in_pkt_eop),
    .in_pkt_empty(in_pkt_empty), .in_pkt_valid(in_pkt_valid), .in_pkt_ready(in_pkt_ready),
    .in_meta_action(in_meta_action), .in_meta_valid(in_meta_valid), .in_meta_ready(in_meta_ready),
    .emptylist_data(emptylist_data), .emptylist_valid(emptylist_valid), .emptylist_ready(emptylist_ready),
    .pdu_gen_data(pdu_gen_data), .pdu_gen_sop(pdu_gen_sop), .pdu_gen_eop(pdu_gen_eop),
    .pdu_gen_empty(pdu_gen_empty), .pdu_gen_valid(pdu_gen_valid), .pdu_gen_ready(pdu_gen_ready),
    .pdu_gen_almost_full(pdu_gen_almost_full),
    .pdumeta_gen_data(pdumeta_gen_data), .pdumeta_gen_valid(pdumeta_gen_valid),
    .pdumeta_gen_ready(pdumeta_gen_ready),
    .stat_pkts(stat_pkts), .stat_trunc(stat_trunc), .err_sticky(err_sticky)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [511:0] data;
    logic         sop;
    logic         eop;
    logic [5:0]   empty;
  } flit_t;

  flit_t         exp_flit_q[$];
  pdu_metadata_t exp_meta_q[$];
  flit_t         mon_act, mon_exp;
  pdu_metadata_t mon_mact, mon_mexp;
  int            vectors = 0;
  int            miscompares = 0;
  int            pop_cnt = 0;
  int            pkt_num = 0;
  bit            mon_en = 1'b1;

  function automatic logic [511:0] pat(input int p, input int i);
    logic [31:0] w;
    w = {p[15:0], i[15:0]};
    return {16{w}};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en && pdu_gen_valid) begin
      vectors++;
      mon_act = '{pdu_gen_data, pdu_gen_sop, pdu_gen_eop, pdu_gen_empty};
      if (exp_flit_q.size() == 0) begin
        miscompares++;
        $display("FAIL flit_unexpected: got word0=%h sop=%0b eop=%0b empty=%0d, required no flit",
                 mon_act.data[31:0], mon_act.sop, mon_act.eop, mon_act.empty);
      end else begin
        mon_exp = exp_flit_q.pop_front();
        if (mon_act !== mon_exp) begin
          miscompares++;
          $display("FAIL flit: got word0=%h sop=%0b eop=%0b empty=%0d, required word0=%h sop=%0b eop=%0b empty=%0d",
                   mon_act.data[31:0], mon_act.sop, mon_act.eop, mon_act.empty,
                   mon_exp.data[31:0], mon_exp.sop, mon_exp.eop, mon_exp.empty);
        end
      end
    end
    if (mon_en && pdumeta_gen_valid && pdumeta_gen_ready) begin
      vectors++;
      mon_mact = pdumeta_gen_data;
      if (exp_meta_q.size() == 0) begin
        miscompares++;
        $display("FAIL meta_unexpected: got id=%0d flits=%0d size=%0d, required no meta",
                 mon_mact.pdu_id, mon_mact.flits, mon_mact.pdu_size);
      end else begin
        mon_mexp = exp_meta_q.pop_front();
        if (mon_mact !== mon_mexp) begin
          miscompares++;
          $display("FAIL meta: got id=%0d act=%0d flits=%0d size=%0d, required id=%0d act=%0d flits=%0d size=%0d",
                   mon_mact.pdu_id, mon_mact.action, mon_mact.flits, mon_mact.pdu_size,
                   mon_mexp.pdu_id, mon_mexp.action, mon_mexp.flits, mon_mexp.pdu_size);
        end
      end
    end
    if (emptylist_valid && emptylist_ready) pop_cnt++;
  end

  task automatic wait_acc(input string name);
    int t;
    t = 0;
    @(negedge clk);
    while (!in_pkt_ready && t < 200) begin
      t++;
      @(negedge clk);
    end
    if (!in_pkt_ready) begin
      vectors++;
      miscompares++;
      $display("FAIL %s_timeout: in_pkt_ready=0 after %0d cycles, required 1", name, t);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    repeat (4) @(posedge clk);
    #1;
  endtask

  // exp_n/exp_size are the hand-computed PDU length and byte size; exp_n=0 means no output.
  task automatic send_pkt(input logic [1:0] act, input logic [7:0] id, input int n,
                          input logic [5:0] emp, input int exp_n, input logic [10:0] exp_size,
                          input int bad_sop);
    flit_t         f;
    pdu_metadata_t m;
    pkt_num++;
    for (int i = 0; i < exp_n; i++) begin
      f.data  = pat(pkt_num, i);
      f.sop   = (i == 0);
      f.eop   = (i == exp_n - 1);
      f.empty = (i == exp_n - 1 && n == exp_n) ? emp : 6'd0;
      exp_flit_q.push_back(f);
    end
    if (exp_n > 0) begin
      m.pdu_id   = (act == ACTION_CHECK) ? id : 8'd0;
      m.action   = act;
      m.flits    = 5'(exp_n);
      m.pdu_size = exp_size;
      exp_meta_q.push_back(m);
    end
    in_meta_valid  = 1'b1;
    in_meta_action = act;
    emptylist_data = id;
    for (int i = 0; i < n; i++) begin
      in_pkt_valid = 1'b1;
      in_pkt_data  = pat(pkt_num, i);
      in_pkt_sop   = (i == 0) || (i == bad_sop);
      in_pkt_eop   = (i == n - 1);
      in_pkt_empty = (i == n - 1) ? emp : 6'd0;
      wait_acc("pkt_flit");
      if (i == 0) in_meta_valid = 1'b0;
    end
    in_pkt_valid = 1'b0;
    in_pkt_sop   = 1'b0;
    in_pkt_eop   = 1'b0;
  endtask

  task automatic bp(input int kind, input string name);
    int acc;
    acc = 0;
    if (kind == 2) begin
      pdumeta_gen_ready = 1'b0;
      send_pkt(ACTION_NOCHECK, 8'h00, 1, 6'd0, 1, 11'd64, -1);
    end else if (kind == 0) begin
      emptylist_valid = 1'b0;
    end else begin
      pdu_gen_almost_full = 1'b1;
    end
    in_meta_valid  = 1'b1;
    in_meta_action = ACTION_CHECK;
    emptylist_data = 8'h21;
    in_pkt_valid   = 1'b1;
    in_pkt_sop     = 1'b1;
    in_pkt_eop     = 1'b0;
    in_pkt_data    = pat(pkt_num + 1, 0);
    repeat (20) begin
      @(negedge clk);
      if (in_pkt_ready || in_meta_ready || emptylist_ready) acc++;
    end
    chk(name, 64'(acc), 64'd0);
    @(posedge clk);
    #1;
    emptylist_valid     = 1'b1;
    pdu_gen_almost_full = 1'b0;
    pdumeta_gen_ready   = 1'b1;
    send_pkt(ACTION_CHECK, 8'h21, 2, 6'd3, 2, 11'd125, -1);
    wait_idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int p0;
    rst = 1'b0;
    in_pkt_data = '0; in_pkt_sop = 1'b0; in_pkt_eop = 1'b0; in_pkt_empty = '0; in_pkt_valid = 1'b0;
    in_meta_action = '0; in_meta_valid = 1'b0;
    emptylist_data = '0; emptylist_valid = 1'b1;
    pdu_gen_ready = 1'b1; pdu_gen_almost_full = 1'b0; pdumeta_gen_ready = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_valids_readys", {59'd0, pdu_gen_valid, pdumeta_gen_valid, in_pkt_ready, in_meta_ready, emptylist_ready}, 64'd0);
    chk("rst_stats", {stat_pkts, stat_trunc}, 64'd0);
    chk("rst_err", 64'(err_sticky), 64'd0);
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    #1;

    p0 = pop_cnt;
    send_pkt(ACTION_CHECK, 8'd7, 3, 6'd10, 3, 11'd182, -1);
    wait_idle();
    chk("check_pkt_pops", 64'(pop_cnt - p0), 64'd1);

    p0 = pop_cnt;
    send_pkt(ACTION_NOCHECK, 8'h33, 1, 6'd0, 1, 11'd64, -1);
    wait_idle();
    chk("nocheck_pkt_pops", 64'(pop_cnt - p0), 64'd0);
    chk("stat_pkts_2", 64'(stat_pkts), 64'd2);

    in_pkt_valid = 1'b1; in_pkt_sop = 1'b0; in_pkt_eop = 1'b1; in_pkt_data = pat(999, 0);
    wait_acc("stray_flit");
    in_pkt_valid = 1'b0; in_pkt_eop = 1'b0;
    wait_idle();
    chk("stray_flit_err", 64'(err_sticky), 64'd0);

    send_pkt(ACTION_CHECK, 8'd9, 40, 6'd5, 31, 11'd1984, -1);
    wait_idle();
    chk("trunc_stat_trunc", 64'(stat_trunc), 64'd1);
    chk("trunc_stat_pkts", 64'(stat_pkts), 64'd3);

    p0 = pop_cnt;
    send_pkt(2'd3, 8'd0, 5, 6'd0, 0, 11'd0, -1);
    wait_idle();
    chk("discard_pops", 64'(pop_cnt - p0), 64'd0);
    send_pkt(ACTION_NOCHECK, 8'd0, 2, 6'd20, 2, 11'd108, -1);
    wait_idle();
    chk("after_discard_stat_pkts", 64'(stat_pkts), 64'd4);

    bp(0, "bp_emptylist_hold");
    bp(1, "bp_almost_full_hold");
    bp(2, "bp_meta_ready_hold");
    chk("bp_stat_pkts", 64'(stat_pkts), 64'd8);

    send_pkt(ACTION_NOCHECK, 8'd0, 3, 6'd4, 3, 11'd188, 1);
    wait_idle();
    chk("mid_sop_err", 64'(err_sticky), 64'd2);
    chk("mid_sop_stat_pkts", 64'(stat_pkts), 64'd9);

    mon_en = 1'b0;
    pkt_num++;
    in_meta_valid = 1'b1; in_meta_action = ACTION_CHECK; emptylist_data = 8'h44;
    for (int i = 0; i < 4; i++) begin
      in_pkt_valid = 1'b1; in_pkt_data = pat(pkt_num, i);
      in_pkt_sop = (i == 0); in_pkt_eop = 1'b0; in_pkt_empty = '0;
      wait_acc("partial_flit");
      if (i == 0) in_meta_valid = 1'b0;
    end
    in_pkt_data = pat(pkt_num, 4);
    chk("partial_valid_before_rst", 64'(pdu_gen_valid), 64'd1);
    #2 rst = 1'b0;
    #1;
    chk("midrst_outputs", {61'd0, pdu_gen_valid, in_pkt_ready, pdumeta_gen_valid}, 64'd0);
    chk("midrst_stats", {stat_pkts, stat_trunc}, 64'd0);
    chk("midrst_err", 64'(err_sticky), 64'd0);
    in_pkt_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    mon_en = 1'b1;
    @(posedge clk);
    #1;

    p0 = pop_cnt;
    send_pkt(ACTION_CHECK, 8'h05, 2, 6'd0, 2, 11'd128, -1);
    wait_idle();
    chk("post_rst_pops", 64'(pop_cnt - p0), 64'd1);

    pdu_gen_ready = 1'b0;
    send_pkt(ACTION_NOCHECK, 8'd0, 1, 6'd0, 1, 11'd64, -1);
    wait_idle();
    pdu_gen_ready = 1'b1;
    chk("overflow_err", 64'(err_sticky), 64'd1);
    chk("post_rst_stat_pkts", 64'(stat_pkts), 64'd2);

    wait_idle();
    chk("scoreboard_drained", 64'(exp_flit_q.size() + exp_meta_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
